// File: rtl/ccr_flag_writer.sv
// ccr_flag_writer: producer side of the condition code register with compare-flag aging.
// Optional macro CCR_STICKY_OVF_EN makes the overflow/underflow bits sticky. Rev 1.0
`default_nettype none

module ccr_flag_writer #(
  parameter int STALE_CYCLES = 15,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmp_valid,
  output logic        cmp_ready,
  input  logic [2:0]  cmp_sel,
  input  logic [31:0] cmp_result,
  input  logic        stat_valid,
  input  logic [31:0] alu_res,
  input  logic        over,
  input  logic        under,
  input  logic        wb_valid,
  input  logic [31:0] wb_ccr,
  output logic [31:0] ccr_q,
  output logic        flag_pending,
  output logic        expired,
  output logic        err_sel
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] AGE_LAST = CNT_W'(STALE_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] age, age_n;
  logic [5:0]       flags, flags_n;
  logic [2:0]       stat, stat_n;
  logic             err_sel_q, err_sel_n;

  logic cmp_acc, sel_legal, cmp_true;
  logic unused_wb_hi;

  assign unused_wb_hi = ^wb_ccr[31:9];

  assign cmp_ready = (state != EXPIRE);
  assign cmp_acc   = cmp_valid && cmp_ready;
  assign sel_legal = (cmp_sel <= 3'd5);
  assign cmp_true  = (cmp_result == 32'd1);

  always_comb begin
    state_n   = state;
    age_n     = age;
    flags_n   = flags;
    err_sel_n = 1'b0;

    if (cmp_acc) begin
      // A new compare owns the flag field regardless of state.
      age_n     = '0;
      err_sel_n = !sel_legal;
      if (sel_legal && cmp_true) begin
        flags_n = 6'b1 << cmp_sel;
        state_n = ARMED;
      end else begin
        flags_n = '0;
        state_n = IDLE;
      end
    end else begin
      case (state)
        ARMED: begin
          if (wb_valid) flags_n = wb_ccr[8:3];
          if (wb_valid && (wb_ccr[8:3] == 6'd0)) begin
            state_n = IDLE;
            age_n   = '0;
          end else if (age == AGE_LAST) begin
            state_n = EXPIRE;
            age_n   = '0;
          end else begin
            age_n = age + 1'b1;
          end
        end
        EXPIRE: begin
          flags_n = '0;
          age_n   = '0;
          state_n = IDLE;
        end
        default: begin
          flags_n = '0;
          age_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stat_n = stat;
    if (stat_valid) begin
`ifdef CCR_STICKY_OVF_EN
      stat_n = {stat[2] | under, stat[1] | over, (alu_res == 32'd0)};
`else
      stat_n = {under, over, (alu_res == 32'd0)};
`endif
    end else if (wb_valid) begin
      stat_n = wb_ccr[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      age       <= '0;
      flags     <= '0;
      stat      <= '0;
      err_sel_q <= 1'b0;
    end else begin
      state     <= state_n;
      age       <= age_n;
      flags     <= flags_n;
      stat      <= stat_n;
      err_sel_q <= err_sel_n;
    end
  end

  assign ccr_q        = {23'd0, flags, stat};
  assign flag_pending = (state == ARMED);
  assign expired      = (state == EXPIRE);
  assign err_sel      = err_sel_q;

endmodule

`default_nettype wire

// File: doc/ccr_flag_writer.md
Name: ccr_flag_writer

Overview:
Producer side of the condition code register (CCR). Holds the architectural CCR and owns the state behind it. Captures ALU status bits [2:0] and compare-result flags [8:3] from the execute stage. Presents the CCR each cycle to the branch-consume logic, and accepts that logic's write-back, so that a flag consumed by a branch stays cleared. Flags that no branch consumes within a bounded window are aged out.

Parameters:
STALE_CYCLES, 15, cycles a compare flag may stay pending before it is auto-cleared (1..2^CNT_W-1)
CNT_W, 4, width of the age counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmp_valid  input  1  execute stage presents a compare result
cmp_ready  output  1  block can accept a compare this cycle
cmp_sel  input  3  relation: 0 EQ, 1 NEQ, 2 LT, 3 LTE, 4 GT, 5 GTE, 6-7 illegal
cmp_result  input  32  ALU compare output; 32'b1 means true, any other value means false
stat_valid  input  1  ALU status update this cycle
alu_res  input  32  ALU result, used for the zero flag
over  input  1  ALU overflow
under  input  1  ALU underflow
wb_valid  input  1  branch-consume logic is writing the CCR back this cycle
wb_ccr  input  32  CCR value written back by branch-consume logic
ccr_q  output  32  registered CCR
flag_pending  output  1  a compare flag in [8:3] is set and waiting
expired  output  1  one-cycle pulse: a pending flag aged out
err_sel  output  1  one-cycle pulse: a compare with illegal cmp_sel was accepted

Behaviour:
- Reset, async on rst_n low:
  - ccr_q=0, state=IDLE, age=0
  - flag_pending=0, expired=0, err_sel=0
  - cmp_ready=1 once reset is released.
- ccr_q[31:9] are always 0. Writes to those bits are discarded.
- Handshake: a compare is accepted when cmp_valid&&cmp_ready. The accepted compare is reflected in ccr_q the next cycle (1-cycle latency).
- cmp_ready=0 only in state EXPIRE; otherwise cmp_ready=1.
- Accepted compare with legal sel and cmp_result==32'b1:
  - ccr_q[8:3] becomes one-hot, bit (3+sel).
  - age=0
  - state goes to ARMED.
- Accepted compare with legal sel and a false result: ccr_q[8:3]=0, state goes to IDLE.
- Accepted compare with sel 6 or 7: ccr_q[8:3]=0, err_sel pulses, state goes to IDLE.
- States:
  - IDLE: [8:3]==0, no aging.
  - ARMED:
    - age increments every cycle.
    - If a wb_valid arrives carrying wb_ccr[8:3]==0 (flag consumed), go to IDLE.
    - When age==STALE_CYCLES-1 with no consume or new compare, go to EXPIRE.
  - EXPIRE: lasts one cycle.
    - ccr_q[8:3] cleared at the end of the cycle.
    - expired=1 registered for that cycle.
    - Next state is IDLE.
- flag_pending = (state==ARMED).
- Status bits, updated when stat_valid:
  - ccr_q[0] = (alu_res==0)
  - ccr_q[1] = over
  - ccr_q[2] = under
  - Without stat_valid, these bits hold.
- Write-back: when wb_valid, load ccr_q[8:0] from wb_ccr[8:0], subject to the priority rules below.
- Priority when events coincide, highest first:
  1. An accepted compare owns [8:3].
  2. stat_valid owns [2:0].
  3. wb_valid fills any field not claimed above.
  4. Aging applies last.
- A compare accepted in ARMED replaces the flag and restarts age at 0.
- wb_valid in IDLE with nonzero wb_ccr[8:3] is ignored for [8:3], which stay 0.
- Reset asserted mid-ARMED clears everything immediately, with no expired pulse.

Optional Feature:
CCR_STICKY_OVF_EN:
- Defined: ccr_q[1] and ccr_q[2] are sticky. stat_valid can only set them (OR with over/under). They clear only through wb_valid carrying 0 in that bit.
- Undefined: they follow over/under on each stat_valid, as described in Behaviour.

Test Plan:
1. Reset, then release rst_n: ccr_q==0, cmp_ready==1, flag_pending==0.
2. cmp_valid, sel=2, cmp_result=32'b1, then wb_valid with wb_ccr=0 two cycles later: ccr_q==32'h20 the cycle after accept; then ccr_q[8:3]==0 and flag_pending==0.
3. sel=0 true, then no consume for STALE_CYCLES=15 cycles: expired pulses exactly once, cmp_ready==0 in that cycle, ccr_q[8:3]==0 afterwards.
4. Same cycle: cmp_valid sel=5 true, wb_valid wb_ccr=32'h1FF, stat_valid alu_res=0 over=1: ccr_q==32'h103 next cycle.
5. cmp_valid sel=7: err_sel pulses once, ccr_q[8:3]==0. Then sel=1 with cmp_result=32'h2 (false): [8:3] stays 0.
6. Build with CCR_STICKY_OVF_EN: stat_valid over=1, then stat_valid over=0: ccr_q[1] stays 1 until wb_valid writes wb_ccr[1]=0. Without the macro, ccr_q[1] drops to 0 on the second stat_valid.
